// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared widths and FSM states for the servo pulse decoder
package servo_pkg;

  localparam int LEVEL_W   = 3;
  localparam int WIDTH_W   = 12;
  localparam int TIMEOUT_W = 15;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_e;

endpackage

// File: rtl/servo_us_tick.sv
// rtl/servo_us_tick.sv - microsecond prescaler with synchronous restart
module servo_us_tick #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_US - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap at the terminal count; a restart aligns the next tick to a full microsecond.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == TERMINAL) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - RC servo pulse width to 3-bit level index; optional SERVO_FILTER_EN
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int CLKS_PER_US    = 50,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int TOL_US         = 200,
  parameter int TIMEOUT_US     = 25000,
  parameter int FAILSAFE_LEVEL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               servoIn,
  output logic [LEVEL_W-1:0] dutyCycleLookup,
  output logic               pulseValid,
  output logic               signalLost
);

  localparam int STEP_US = (MAX_US - MIN_US) / 8;
  localparam logic [WIDTH_W-1:0]   ACC_MIN_W  = WIDTH_W'(MIN_US - TOL_US);
  localparam logic [WIDTH_W-1:0]   ACC_MAX_W  = WIDTH_W'(MAX_US + TOL_US);
  localparam logic [WIDTH_W-1:0]   MIN_W      = WIDTH_W'(MIN_US);
  localparam logic [WIDTH_W-1:0]   MAX_W      = WIDTH_W'(MAX_US);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_W_ = TIMEOUT_W'(TIMEOUT_US);
  localparam logic [LEVEL_W-1:0]   FAILSAFE_W = LEVEL_W'(FAILSAFE_LEVEL);

  logic sync1_q, sync2_q, prev_q;
  logic rise, fall;

  state_e state_q, state_d;
  logic [WIDTH_W-1:0]   width_q, width_d, width_next;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d, to_cnt_next;
  logic [LEVEL_W-1:0]   duty_q, duty_d;
  logic                 valid_q, valid_d;
  logic                 lost_q, lost_d;
  logic                 us_tick, to_tick;
  logic                 accept, to_expired;
  logic [WIDTH_W-1:0]   clamped;
  logic [LEVEL_W-1:0]   idx;

`ifdef SERVO_FILTER_EN
  logic [LEVEL_W-1:0] last_idx_q, last_idx_d;
  logic               last_vld_q, last_vld_d;
`endif

  // Synchroniser and edge history; reset to 1 so a pulse in flight at reset
  // release never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= servoIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  servo_us_tick #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_width_tick (
    .clk      (clk),
    .reset    (reset),
    .restart_i(rise),
    .tick_o   (us_tick)
  );

  servo_us_tick #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_timeout_tick (
    .clk      (clk),
    .reset    (reset),
    .restart_i(accept),
    .tick_o   (to_tick)
  );

  // Saturating next values; the width includes the tick of the falling-edge cycle.
  assign width_next  = (us_tick && (width_q != {WIDTH_W{1'b1}})) ? width_q + WIDTH_W'(1) : width_q;
  assign to_cnt_next = (to_tick && (to_cnt_q != {TIMEOUT_W{1'b1}})) ? to_cnt_q + TIMEOUT_W'(1) : to_cnt_q;
  assign to_expired  = (to_cnt_next >= TIMEOUT_W_);

  // Clamp the measured width and quantise with a threshold ladder.
  always_comb begin
    clamped = width_next;
    if (width_next < MIN_W) begin
      clamped = MIN_W;
    end else if (width_next > MAX_W) begin
      clamped = MAX_W;
    end
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (clamped >= WIDTH_W'(MIN_US + k * STEP_US)) begin
        idx = idx + LEVEL_W'(1);
      end
    end
  end

  // FSM next state, acceptance, timeout and output next values; acceptance beats expiry.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;
    to_cnt_d = to_cnt_next;
    accept   = 1'b0;
`ifdef SERVO_FILTER_EN
    last_idx_d = last_idx_q;
    last_vld_d = last_vld_q;
`endif

    case (state_q)
      WAIT_LOW: begin
        if (!sync2_q) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          width_d = '0;
        end
      end
      MEASURE: begin
        width_d = width_next;
        if (fall) begin
          state_d = WAIT_RISE;
          accept  = (width_next >= ACC_MIN_W) && (width_next <= ACC_MAX_W);
        end else if (width_next > ACC_MAX_W) begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase

    if (to_expired) begin
      lost_d = 1'b1;
      duty_d = FAILSAFE_W;
`ifdef SERVO_FILTER_EN
      last_idx_d = '0;
      last_vld_d = 1'b0;
`endif
    end

    if (accept) begin
      to_cnt_d = '0;
      lost_d   = 1'b0;
`ifdef SERVO_FILTER_EN
      last_idx_d = idx;
      last_vld_d = 1'b1;
      if (last_vld_q && (last_idx_q == idx)) begin
        duty_d  = idx;
        valid_d = 1'b1;
      end
`else
      duty_d  = idx;
      valid_d = 1'b1;
`endif
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOW;
      width_q  <= '0;
      to_cnt_q <= '0;
      duty_q   <= FAILSAFE_W;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      to_cnt_q <= to_cnt_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

`ifdef SERVO_FILTER_EN
  // Index of the previous accepted pulse for the repeat filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_idx_q <= last_idx_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

  assign dutyCycleLookup = duty_q;
  assign pulseValid      = valid_q;
  assign signalLost      = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - directed self-checking bench for servo_pulse_decoder
module tb_servo_pulse_decoder;
  import servo_pkg::*;

  localparam int CPU   = 2;
  localparam int TO_US = 8000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       servoIn = 1'b0;
  logic [2:0] duty;
  logic       pv;
  logic       lost;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int s0;
  logic [2:0] exp_duty;
  logic       exp_lost;

  always #5 clk = ~clk;

  servo_pulse_decoder #(
    .CLKS_PER_US   (CPU),
    .MIN_US        (1000),
    .MAX_US        (2000),
    .TOL_US        (200),
    .TIMEOUT_US    (TO_US),
    .FAILSAFE_LEVEL(0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .servoIn        (servoIn),
    .dutyCycleLookup(duty),
    .pulseValid     (pv),
    .signalLost     (lost)
  );

  always @(posedge clk) if (pv === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int us);
    repeat (us * CPU) @(negedge clk);
  endtask

  // Low gap, high pulse of us microseconds, then checks at E1, E2 and E3.
  task automatic send_pulse(input string tag, input int us, input bit acc, input bit strobe,
                            input logic [2:0] idx);
    idle(50);
    servoIn = 1'b1;
    repeat (us * CPU) @(negedge clk);
    servoIn = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_pv_e1"}, 32'(pv), 32'(0));
    chk({tag, "_duty_e1"}, 32'(duty), 32'(exp_duty));
    chk({tag, "_lost_e1"}, 32'(lost), 32'(exp_lost));
    @(negedge clk);
    if (acc) exp_lost = 1'b0;
    if (strobe) exp_duty = idx;
    chk({tag, "_pv_e2"}, 32'(pv), 32'(strobe));
    chk({tag, "_duty_e2"}, 32'(duty), 32'(exp_duty));
    chk({tag, "_lost_e2"}, 32'(lost), 32'(exp_lost));
    @(negedge clk);
    chk({tag, "_pv_e3"}, 32'(pv), 32'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty), 32'(0));
    chk("rst_pv", 32'(pv), 32'(0));
    chk("rst_lost", 32'(lost), 32'(1));
    chk("rst_state", 32'(dut.state_q), 32'(WAIT_LOW));
    reset = 1'b0;
    exp_duty = 3'd0;
    exp_lost = 1'b1;

`ifndef SERVO_FILTER_EN
    send_pulse("p1500", 1500, 1'b1, 1'b1, 3'd4);
    send_pulse("p1000", 1000, 1'b1, 1'b1, 3'd0);
    send_pulse("p1124", 1124, 1'b1, 1'b1, 3'd0);
    send_pulse("p1125", 1125, 1'b1, 1'b1, 3'd1);
    send_pulse("p2000", 2000, 1'b1, 1'b1, 3'd7);
    send_pulse("p850", 850, 1'b1, 1'b1, 3'd0);
    send_pulse("p2150", 2150, 1'b1, 1'b1, 3'd7);
    send_pulse("p700", 700, 1'b0, 1'b0, 3'd0);

    // Over-long pulse: abandoned once the width passes 2200 us.
    idle(50);
    s0 = strobe_cnt;
    servoIn = 1'b1;
    repeat (2201 * CPU + 2) @(negedge clk);
    chk("p2300_state_2200", 32'(dut.state_q), 32'(MEASURE));
    @(negedge clk);
    chk("p2300_state_2201", 32'(dut.state_q), 32'(WAIT_LOW));
    repeat (99 * CPU - 3) @(negedge clk);
    servoIn = 1'b0;
    repeat (6) @(negedge clk);
    chk("p2300_strobes", 32'(strobe_cnt), 32'(s0));
    chk("p2300_duty", 32'(duty), 32'(exp_duty));

    // Loss of signal after the last accepted pulse.
    send_pulse("p1600", 1600, 1'b1, 1'b1, 3'd4);
    s0 = strobe_cnt;
    repeat (TO_US * CPU - 2) @(negedge clk);
    chk("to_lost_before", 32'(lost), 32'(0));
    chk("to_duty_before", 32'(duty), 32'(4));
    @(negedge clk);
    chk("to_lost", 32'(lost), 32'(1));
    chk("to_duty", 32'(duty), 32'(0));
    chk("to_strobes", 32'(strobe_cnt), 32'(s0));
    exp_duty = 3'd0;
    exp_lost = 1'b1;
    send_pulse("p1900", 1900, 1'b1, 1'b1, 3'd7);

    // Reset in the middle of a pulse; the remainder must be ignored.
    idle(50);
    servoIn = 1'b1;
    repeat (400 * CPU) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_duty", 32'(duty), 32'(0));
    chk("midrst_pv", 32'(pv), 32'(0));
    chk("midrst_lost", 32'(lost), 32'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    repeat (700 * CPU) @(negedge clk);
    servoIn = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_strobes", 32'(strobe_cnt), 32'(s0));
    chk("midrst_duty_after", 32'(duty), 32'(0));
    exp_duty = 3'd0;
    exp_lost = 1'b1;
    send_pulse("p1300", 1300, 1'b1, 1'b1, 3'd2);

    send_pulse("nf1500", 1500, 1'b1, 1'b1, 3'd4);
    send_pulse("nf1800a", 1800, 1'b1, 1'b1, 3'd6);
    send_pulse("nf1800b", 1800, 1'b1, 1'b1, 3'd6);
`else
    send_pulse("f1500", 1500, 1'b1, 1'b0, 3'd0);
    send_pulse("f1800a", 1800, 1'b1, 1'b0, 3'd0);
    send_pulse("f1800b", 1800, 1'b1, 1'b1, 3'd6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/servo_pulse_decoder.md
Name: servo_pulse_decoder

Overview:
- Upstream stage of the servo extender PWM generator. Measures the high time of an RC servo input pulse (nominal 1000–2000 us, ~50 Hz frame).
- Quantises the width into the 3-bit duty-cycle lookup index the PWM stage consumes.
- Holds the last good value between frames. Forces a failsafe index when frames stop arriving.

Parameters:
- CLKS_PER_US, 50, clk cycles per microsecond (50 MHz clk).
- MIN_US, 1000, pulse width mapped to index 0.
- MAX_US, 2000, pulse width mapped to index 7.
- TOL_US, 200, accepted overshoot outside [MIN_US, MAX_US] before a pulse is rejected.
- TIMEOUT_US, 25000, time without an accepted pulse before signal is declared lost.
- FAILSAFE_LEVEL, 0, index driven while signal is lost.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- servoIn  input  1  raw, asynchronous servo pulse input.
- dutyCycleLookup  output  3  quantised width index, registered.
- pulseValid  output  1  one-cycle strobe when dutyCycleLookup is updated from an accepted pulse.
- signalLost  output  1  high while no accepted pulse has arrived within TIMEOUT_US.

Behaviour:
- Reset values: dutyCycleLookup=FAILSAFE_LEVEL, pulseValid=0, signalLost=1, FSM=WAIT_LOW, all counters 0.
- Input path:
  - servoIn passes a 2-flop synchroniser plus a previous-value flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Microsecond tick: prescaler counts 0..CLKS_PER_US-1 and emits a 1-cycle usTick at terminal count. A rising edge forces it to 0, so a pulse of N whole us yields exactly N ticks.
- Width counter: 12 bits, counts usTick while in MEASURE, saturates at 4095.
- FSM:
  - WAIT_LOW → WAIT_RISE when sync==0. Prevents measuring a partial pulse after reset.
  - WAIT_RISE → MEASURE on rise. Width counter and prescaler cleared.
  - MEASURE → WAIT_RISE on fall. The pulse is evaluated in the same cycle.
  - MEASURE → WAIT_LOW when width > MAX_US+TOL_US. Pulse rejected, no strobe.
- Acceptance: width in [MIN_US-TOL_US, MAX_US+TOL_US]. Rejected pulses leave all outputs unchanged.
- Quantisation:
  - Clamp width to [MIN_US, MAX_US].
  - STEP = (MAX_US-MIN_US)/8 (integer, elaboration-time) = 125.
  - Index = count of k in 1..7 with clamped >= MIN_US + k*STEP. Implemented as a compare ladder with no runtime division.
  - Defaults give: 1000–1124→0, 1125–1249→1, …, 1875–2000→7.
- Latency:
  - The first clk edge sampling servoIn low is E0.
  - dutyCycleLookup and pulseValid update at E2.
  - pulseValid deasserts at E3.
- Timeout:
  - 15-bit us counter, cleared on every accepted pulse, saturates.
  - On reaching TIMEOUT_US: signalLost=1 and dutyCycleLookup=FAILSAFE_LEVEL. No pulseValid strobe.
  - An accepted pulse clears signalLost in the same cycle that dutyCycleLookup updates.
- Simultaneous events: acceptance and timeout expiry in the same cycle → acceptance wins and the timer restarts.
- Reset mid-pulse: outputs return to reset values. The in-flight pulse is ignored via WAIT_LOW.

Optional Feature:
- Macro: SERVO_FILTER_EN.
- Defined: an accepted pulse updates dutyCycleLookup and strobes pulseValid only if its index equals the index of the immediately preceding accepted pulse. A 3-bit last-index register plus a valid bit is added; both are cleared by reset and on timeout. signalLost still clears on any accepted pulse.
- Undefined: every accepted pulse updates the output.

Decomposition:
- Package servo_pkg holds:
  - FSM state enum (WAIT_LOW, WAIT_RISE, MEASURE);
  - LEVEL_W=3;
  - WIDTH_W=12;
  - TIMEOUT_W=15.
- One sub-module: servo_us_tick, the microsecond prescaler with synchronous restart input. It is reused by the timeout counter.

Test Plan:
- 1500 us high pulse after low idle → dutyCycleLookup=4, pulseValid one cycle, signalLost 1→0 at E2 after the falling edge.
- 1000 us, 1124 us, 1125 us and 2000 us pulses → indices 0, 0, 1, 7 respectively.
- 850 us → accepted, clamped, index 0. 2150 us → accepted, index 7. 700 us and 2300 us → no strobe, output unchanged; the 2300 us case enters WAIT_LOW at 2201 us.
- Valid 1600 us pulse (index 4), then servoIn held low 25000 us → signalLost=1, dutyCycleLookup=0, no strobe. The next 1900 us pulse → index 7, signalLost=0.
- Assert reset 400 us into a high pulse, release while servoIn is still high → no strobe for that pulse. The next full 1300 us pulse → index 2.
- SERVO_FILTER_EN defined: pulses of 1500, 1800, 1800 us → strobes only on the third pulse, index 6. Undefined → three strobes, indices 4, 6, 6.
